// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - FIFO pointer/occupancy controller with edge or strobe triggers
// Wrapping read/write addresses, occupancy count, full/empty/almost flags, sticky errors.
module fifo_ptr_ctrl #(
  parameter int DEPTH     = 4,
  parameter bit EDGE_TRIG = 1'b1,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1,
  localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          trig_write,
  input  logic          trig_read,
  input  logic          clr_flags,
  output logic          wr_en,
  output logic          rd_en,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);

  logic          wprev_q, rprev_q;
  logic          wr_req, rd_req, wr_acc, rd_acc;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          afull_q, afull_d, aempty_q, aempty_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;

  always_comb begin
    if (EDGE_TRIG) begin
      wr_req = trig_write & ~wprev_q;
      rd_req = trig_read & ~rprev_q;
    end else begin
      wr_req = trig_write;
      rd_req = trig_read;
    end
    // No fall-through: a read at empty is refused even alongside a write.
    rd_acc = rd_req & ~empty_q;
    wr_acc = wr_req & (~full_q | rd_req);

    wr_ptr_d = wr_ptr_q;
    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    rd_ptr_d = rd_ptr_q;
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    end

    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CW'(AFULL_TH));
    aempty_d = (count_d <= CW'(AEMPTY_TH));
    // A fresh error outranks a same-cycle clear.
    ovf_d = (wr_req & ~wr_acc) | (ovf_q & ~clr_flags);
    unf_d = (rd_req & ~rd_acc) | (unf_q & ~clr_flags);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wprev_q  <= 1'b0;
      rprev_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= (AFULL_TH == 0);
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wprev_q  <= trig_write;
      rprev_q  <= trig_read;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign wr_en        = wr_acc;
  assign rd_en        = rd_acc;
  assign wr_ptr       = wr_ptr_q;
  assign rd_ptr       = rd_ptr_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb/tb_fifo_ptr_ctrl.sv - scoreboard bench for fifo_ptr_ctrl across three configurations
module tb_fifo_ptr_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic tw, tr, clr;
  int   sel;
  int   checks = 0;
  int   errors = 0;

  // Config A: DEPTH=5 edge; B: DEPTH=4 strobe; C: DEPTH=3 strobe
  logic a_tw, a_tr, a_clr, b_tw, b_tr, b_clr, c_tw, c_tr, c_clr;
  assign a_tw = (sel == 0) & tw;  assign a_tr = (sel == 0) & tr;  assign a_clr = (sel == 0) & clr;
  assign b_tw = (sel == 1) & tw;  assign b_tr = (sel == 1) & tr;  assign b_clr = (sel == 1) & clr;
  assign c_tw = (sel == 2) & tw;  assign c_tr = (sel == 2) & tr;  assign c_clr = (sel == 2) & clr;

  logic       a_wen, a_ren, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [2:0] a_wp, a_rp, a_cnt;
  logic       b_wen, b_ren, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [1:0] b_wp, b_rp;
  logic [2:0] b_cnt;
  logic       c_wen, c_ren, c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
  logic [1:0] c_wp, c_rp, c_cnt;

  fifo_ptr_ctrl #(.DEPTH(5), .EDGE_TRIG(1'b1), .AFULL_TH(4), .AEMPTY_TH(1)) u_a (
    .clk(clk), .rst_n(rst_n), .trig_write(a_tw), .trig_read(a_tr), .clr_flags(a_clr),
    .wr_en(a_wen), .rd_en(a_ren), .wr_ptr(a_wp), .rd_ptr(a_rp), .count(a_cnt),
    .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
    .overflow(a_ovf), .underflow(a_unf));

  fifo_ptr_ctrl #(.DEPTH(4), .EDGE_TRIG(1'b0), .AFULL_TH(3), .AEMPTY_TH(1)) u_b (
    .clk(clk), .rst_n(rst_n), .trig_write(b_tw), .trig_read(b_tr), .clr_flags(b_clr),
    .wr_en(b_wen), .rd_en(b_ren), .wr_ptr(b_wp), .rd_ptr(b_rp), .count(b_cnt),
    .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
    .overflow(b_ovf), .underflow(b_unf));

  fifo_ptr_ctrl #(.DEPTH(3), .EDGE_TRIG(1'b0), .AFULL_TH(2), .AEMPTY_TH(1)) u_c (
    .clk(clk), .rst_n(rst_n), .trig_write(c_tw), .trig_read(c_tr), .clr_flags(c_clr),
    .wr_en(c_wen), .rd_en(c_ren), .wr_ptr(c_wp), .rd_ptr(c_rp), .count(c_cnt),
    .full(c_full), .empty(c_empty), .almost_full(c_af), .almost_empty(c_ae),
    .overflow(c_ovf), .underflow(c_unf));

  logic       m_wen, m_ren;
  int         m_wp, m_rp, m_cnt, m_depth;
  logic [5:0] m_fl;

  always_comb begin
    m_wen = a_wen; m_ren = a_ren; m_wp = int'(a_wp); m_rp = int'(a_rp);
    m_cnt = int'(a_cnt); m_depth = 5;
    m_fl = {a_full, a_empty, a_af, a_ae, a_ovf, a_unf};
    if (sel == 1) begin
      m_wen = b_wen; m_ren = b_ren; m_wp = int'(b_wp); m_rp = int'(b_rp);
      m_cnt = int'(b_cnt); m_depth = 4;
      m_fl = {b_full, b_empty, b_af, b_ae, b_ovf, b_unf};
    end else if (sel == 2) begin
      m_wen = c_wen; m_ren = c_ren; m_wp = int'(c_wp); m_rp = int'(c_rp);
      m_cnt = int'(c_cnt); m_depth = 3;
      m_fl = {c_full, c_empty, c_af, c_ae, c_ovf, c_unf};
    end
  end

  typedef struct {
    bit         wen;
    bit         ren;
    int         cnt;
    int         wp;
    int         rp;
    logic [5:0] fl;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s sel=%0d t=%0t actual=%0d required=%0d", nm, sel, $time, act, req);
    end
  endtask

  // Flags order: {full, empty, almost_full, almost_empty, overflow, underflow}
  task automatic issue(input bit w, input bit r, input bit c, input bit wen, input bit ren,
                       input int cnt, input int wp, input int rp, input logic [5:0] fl);
    exp_t e;
    tw = w; tr = r; clr = c;
    e.wen = wen; e.ren = ren; e.cnt = cnt; e.wp = wp; e.rp = rp; e.fl = fl;
    exp_q.push_back(e);
  endtask

  task automatic vec(input bit w, input bit r, input bit c, input bit wen, input bit ren,
                     input int cnt, input int wp, input int rp, input logic [5:0] fl);
    @(posedge clk); #1;
    issue(w, r, c, wen, ren, cnt, wp, rp, fl);
  endtask

  // Edge-triggered pulse: one active cycle, then one idle cycle with state held.
  task automatic pulse(input bit w, input bit r, input bit wen, input bit ren,
                       input int cnt, input int wp, input int rp, input logic [5:0] fl);
    vec(w, r, 1'b0, wen, ren, cnt, wp, rp, fl);
    vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cnt, wp, rp, fl);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    tw = 0; tr = 0; clr = 0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic rst_chk();
    chk("rst_count", m_cnt, 0);
    chk("rst_wr_ptr", m_wp, 0);
    chk("rst_rd_ptr", m_rp, 0);
    chk("rst_flags", int'(m_fl), int'(6'b010100));
  endtask

  // Monitor: enables checked in the issue cycle, registered state one cycle later.
  initial begin
    exp_t cur;
    bit   pend;
    int   inv;
    pend = 0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("count", m_cnt, cur.cnt);
        chk("wr_ptr", m_wp, cur.wp);
        chk("rd_ptr", m_rp, cur.rp);
        chk("flags", int'(m_fl), int'(cur.fl));
        inv = (m_wp - m_rp + m_depth) % m_depth;
        chk("ptr_invariant", inv, (m_cnt == m_depth) ? 0 : m_cnt);
        pend = 0;
      end
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        chk("wr_en", int'(m_wen), int'(cur.wen));
        chk("rd_en", int'(m_ren), int'(cur.ren));
        pend = 1;
      end
    end
  end

  initial begin
    sel = 0; tw = 0; tr = 0; clr = 0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 rst_chk();

    // A: fill to 5 and overflow, then drain and underflow, then clear
    pulse(1, 0, 1, 0, 1, 1, 0, 6'b000100);
    pulse(1, 0, 1, 0, 2, 2, 0, 6'b000000);
    pulse(1, 0, 1, 0, 3, 3, 0, 6'b000000);
    pulse(1, 0, 1, 0, 4, 4, 0, 6'b001000);
    pulse(1, 0, 1, 0, 5, 0, 0, 6'b101000);
    pulse(1, 0, 0, 0, 5, 0, 0, 6'b101010);
    pulse(0, 1, 0, 1, 4, 0, 1, 6'b001010);
    pulse(0, 1, 0, 1, 3, 0, 2, 6'b000010);
    pulse(0, 1, 0, 1, 2, 0, 3, 6'b000010);
    pulse(0, 1, 0, 1, 1, 0, 4, 6'b000110);
    pulse(0, 1, 0, 1, 0, 0, 0, 6'b010110);
    pulse(0, 1, 0, 0, 0, 0, 0, 6'b010111);
    vec(0, 0, 1, 0, 0, 0, 0, 0, 6'b010100);

    // A: level held 10 cycles gives a single write
    vec(1, 0, 0, 1, 0, 1, 1, 0, 6'b000100);
    for (int i = 0; i < 9; i++) vec(1, 0, 0, 0, 0, 1, 1, 0, 6'b000100);
    drain();

    // A: async reset mid-traffic, trigger held across release counts once
    @(posedge clk); #1 tw = 1;
    #2 rst_n = 1'b0;
    #1 rst_chk();
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(1, 0, 0, 1, 0, 1, 1, 0, 6'b000100);
    vec(1, 0, 0, 0, 0, 1, 1, 0, 6'b000100);
    vec(0, 0, 0, 0, 0, 1, 1, 0, 6'b000100);
    drain();

    // B: strobes, simultaneous at full and at empty, set-wins on clear
    sel = 1;
    vec(1, 0, 0, 1, 0, 1, 1, 0, 6'b000100);
    vec(1, 0, 0, 1, 0, 2, 2, 0, 6'b000000);
    vec(1, 0, 0, 1, 0, 3, 3, 0, 6'b001000);
    vec(1, 0, 0, 1, 0, 4, 0, 0, 6'b101000);
    vec(1, 1, 0, 1, 1, 4, 1, 1, 6'b101000);
    vec(0, 1, 0, 0, 1, 3, 1, 2, 6'b001000);
    vec(0, 1, 0, 0, 1, 2, 1, 3, 6'b000000);
    vec(0, 1, 0, 0, 1, 1, 1, 0, 6'b000100);
    vec(0, 1, 0, 0, 1, 0, 1, 1, 6'b010100);
    vec(1, 1, 0, 1, 0, 1, 2, 1, 6'b000101);
    vec(0, 1, 0, 0, 1, 0, 2, 2, 6'b010101);
    vec(0, 1, 1, 0, 0, 0, 2, 2, 6'b010101);
    vec(0, 0, 1, 0, 0, 0, 2, 2, 6'b010100);
    drain();

    // C: non-power-of-two wrap with interleaved pairs, then fill and overflow
    sel = 2;
    for (int i = 0; i < 7; i++) begin
      vec(1, 0, 0, 1, 0, 1, (i + 1) % 3, i % 3, 6'b000100);
      vec(0, 1, 0, 0, 1, 0, (i + 1) % 3, (i + 1) % 3, 6'b010100);
    end
    vec(1, 0, 0, 1, 0, 1, 2, 1, 6'b000100);
    vec(1, 0, 0, 1, 0, 2, 0, 1, 6'b001000);
    vec(1, 0, 0, 1, 0, 3, 1, 1, 6'b101000);
    vec(1, 0, 0, 0, 0, 3, 1, 1, 6'b101010);
    vec(1, 1, 0, 1, 1, 3, 2, 2, 6'b101010);
    drain();

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_ptr_ctrl.md
# fifo_ptr_ctrl

Parametrised FIFO pointer and occupancy controller, the generalised successor of the fixed 0..4 saturating pointer. Edge-detects write/read triggers and keeps wrapping write/read addresses for an external storage array. Tracks occupancy with full/empty/almost flags and sticky overflow/underflow error flags. Sits between the trigger-driven transfer logic and the FIFO data RAM in the communication path.

## Interface

- DEPTH, 4, number of FIFO entries; any integer ≥ 2, not restricted to powers of two.
- EDGE_TRIG, 1, 1: triggers are levels and only rising edges count; 0: triggers are single-cycle strobes and each high cycle counts.
- AFULL_TH, DEPTH-1, almost_full asserts when count ≥ AFULL_TH; range 1..DEPTH.
- AEMPTY_TH, 1, almost_empty asserts when count ≤ AEMPTY_TH; range 0..DEPTH-1.
- Derived, not overridable: AW = max(1, clog2(DEPTH)); CW = clog2(DEPTH+1).
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset; deassertion is synchronous to clk externally.
- trig_write  in  1  write request, synchronous to clk.
- trig_read  in  1  read request, synchronous to clk.
- clr_flags  in  1  clears overflow/underflow; count and pointers are unaffected.
- wr_en  out  1  combinational; write accepted this cycle; RAM writes at wr_ptr on the next edge.
- rd_en  out  1  combinational; read accepted this cycle; RAM entry at rd_ptr is consumed.
- wr_ptr  out  AW  registered write address, 0..DEPTH-1.
- rd_ptr  out  AW  registered read address, 0..DEPTH-1.
- count  out  CW  registered occupancy, 0..DEPTH.
- full / empty  out  1  registered; count==DEPTH / count==0.
- almost_full / almost_empty  out  1  registered; thresholds as above.
- overflow / underflow  out  1  registered, sticky error flags.

## Operation

- Request generation:
  - EDGE_TRIG=1: wr_req = trig_write & ~wprev, where wprev is a register of trig_write; same for rd_req with rprev.
  - wprev and rprev reset to 0, so a trigger already high at reset release counts as one edge in the first cycle.
  - EDGE_TRIG=0: wr_req = trig_write; rd_req = trig_read.
- Acceptance:
  - rd_acc = rd_req & ~empty.
  - wr_acc = wr_req & (~full | rd_req).
  - A write at full is accepted only together with a read.
  - A read at empty is rejected even when a write arrives the same cycle; there is no fall-through.
- Update on each clk edge:
  - wr_ptr advances by 1 on wr_acc; rd_ptr advances by 1 on rd_acc.
  - Both pointers wrap DEPTH-1 → 0.
  - count moves +1 on wr_acc only, −1 on rd_acc only, and is unchanged on both or neither.
- Flags:
  - All flags are computed from next-count, so they are valid in the same cycle as count.
- Errors:
  - overflow sets when wr_req & ~wr_acc; underflow sets when rd_req & ~rd_acc.
  - Both stay set until clr_flags.
  - If clr_flags and a new error coincide, the flag stays set (set wins).
- wr_en = wr_acc and rd_en = rd_acc.
- Invariant: count == (wr_ptr − rd_ptr) mod DEPTH, except that count==DEPTH when full.

## Timing

- Reset (rst_n=0, immediate):
  - wr_ptr=0, rd_ptr=0, count=0, wprev=rprev=0.
  - empty=1, full=0, overflow=0, underflow=0.
  - almost_empty=1 (AEMPTY_TH≥0); almost_full=(AFULL_TH==0), which is 0 for legal values.
- Latency: a trigger first sampled high at edge k updates pointers, count and flags at edge k.
  - wr_en/rd_en are high in the cycle before edge k.
  - Output values are visible after edge k.
- EDGE_TRIG=1 throughput: at most one request per 2 cycles per channel, because the trigger must drop for a cycle.
- EDGE_TRIG=0 throughput: one request per cycle.
- Reset mid-operation: all state returns to reset values asynchronously and any in-flight request is discarded.
- A trigger held high across reset deassertion produces exactly one request.

## Test plan

- Reset with DEPTH=5: pulse rst_n low mid-traffic → count=0, wr_ptr=rd_ptr=0, empty=1, full=0, flags=0 without waiting for a clock edge.
- Fill and overflow, DEPTH=5, EDGE_TRIG=1: 6 write pulses → count 1,2,3,4,5; full=1 after the 5th pulse; almost_full=1 at count 4; 6th pulse gives wr_en=0 and overflow=1; wr_ptr=0 after wrap.
- Drain and underflow, continuing from full: 6 read pulses → count 5→0; rd_ptr wraps to 0; 6th pulse gives rd_en=0, underflow=1 and empty=1; clr_flags clears both flags.
- Simultaneous requests, EDGE_TRIG=0, DEPTH=4:
  - At full, assert both triggers for 1 cycle → both accepted, count stays 4, both pointers advance.
  - At empty, assert both for 1 cycle → write only, count=1, underflow=1.
- Level-trigger hold: hold trig_write high 10 cycles with EDGE_TRIG=1 → exactly one wr_en pulse and count=1.
- Reset-release edge: trig_write high while rst_n rises → count=1 after the first clock edge.
- Non-power-of-two wrap, DEPTH=3, EDGE_TRIG=0: 7 interleaved write/read pairs → wr_ptr sequence 0,1,2,0,…; count never exceeds 3; the pointer-difference invariant holds every cycle.
